uart_tx_arbiter: RTL

Shares the single UART transmit byte channel between several byte producers, such as the program loader's echo path and the core's output path. Today those producers are simply ORed onto the channel. The block grants the channel to one requester at a time with round-robin fairness and a bounded burst length, then drives the UART through a one-entry registered output stage. It sits between the producers and the UART `out_*` handshake.

---
 rtl/uart_tx_arbiter_if.sv | 22 ++
 rtl/uart_tx_arbiter.sv | 78 +++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: producer and UART byte handshakes shared by uart_tx_arbiter
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 2
);
   localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0][7:0] req_data;
   logic [NUM_REQ-1:0]      req_ready;
   logic                    uart_out_valid;
   logic [7:0]              uart_out_data;
   logic                    uart_out_ready;
   logic [GW-1:0]           grant_id;
   logic                    busy;
   modport master (
      output req_valid, req_data, uart_out_ready,
      input  req_ready, uart_out_valid, uart_out_data, grant_id, busy
   );
   modport slave (
      input  req_valid, req_data, uart_out_ready,
      output req_ready, uart_out_valid, uart_out_data, grant_id, busy
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, burst-limited sharing of the UART tx byte channel
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int MAX_BURST = 16
) (
   input logic             clk,
   input logic             reset,
   uart_tx_arbiter_if.slave bus
);
   localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   localparam int BW = $clog2(MAX_BURST + 1);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t        state, state_n;
   logic [GW-1:0] grant, last_grant, sel, idx;
   logic [BW-1:0] burst_count;
   logic          out_valid;
   logic [7:0]    out_data;
   logic          g_valid, g_ready, req_xfer, uart_xfer, release_g;
   assign g_valid   = bus.req_valid[grant];
   assign g_ready   = !out_valid || bus.uart_out_ready;
   assign req_xfer  = state == GRANT && g_valid && g_ready;
   assign uart_xfer = out_valid && bus.uart_out_ready;
   assign release_g = state == GRANT && (!g_valid || (req_xfer && burst_count == BW'(MAX_BURST - 1)));
   // Pick the first valid requester after the last one served, wrapping around
   always_comb begin
      sel = '0;
      idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = GW'((int'(last_grant) + 1 + k) % NUM_REQ);
         sel = bus.req_valid[idx] ? idx : sel;
      end
   end
   // Next state and the combinational ready to the granted requester
   always_comb begin
      state_n       = state;
      bus.req_ready = '0;
      if (state == IDLE) begin
         state_n = |bus.req_valid ? GRANT : IDLE;
      end else begin
         bus.req_ready[grant] = g_ready;
         state_n = release_g ? IDLE : GRANT;
      end
   end
   // State register
   always_ff @(posedge clk) state <= !reset ? IDLE : state_n;
   // Grant, fairness pointer and burst accounting
   always_ff @(posedge clk) begin
      if (!reset) begin
         grant       <= '0;
         last_grant  <= GW'(NUM_REQ - 1);
         burst_count <= '0;
      end else begin
         if (state == IDLE && |bus.req_valid) begin
            grant       <= sel;
            burst_count <= '0;
         end else if (req_xfer) begin
            burst_count <= burst_count + BW'(1);
         end
         if (release_g) last_grant <= grant;
      end
   end
   // One-entry output stage; a refill on the draining edge keeps it full
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (req_xfer) begin
         out_valid <= 1'b1;
         out_data  <= bus.req_data[grant];
      end else if (uart_xfer) begin
         out_valid <= 1'b0;
      end
   end
   assign bus.uart_out_valid = out_valid;
   assign bus.uart_out_data  = out_data;
   assign bus.grant_id       = grant;
   assign bus.busy           = state == GRANT || out_valid;
endmodule
